// File: rtl/pixel_unpack_stream.sv
// pixel_unpack_stream
//
// Unpacks a continuous stream of packed memory words into pixels of
// CHANNELS x PIXEL_DEPTH bits. It also tracks the raster position and
// flags the start of frame, end of line and end of frame.
// Bits are consumed LSB-first: the lowest byte of a word holds the
// earliest bits, and channel 0 of a pixel sits in its lowest bits.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   flush_i       synchronous clear of buffer and raster position
//   word_valid_i  input word valid
//   word_data_i   packed input word
//   word_ready_o  input word accepted when valid && ready
//   pix_valid_o   pixel available
//   pix_ready_i   pixel consumed when valid && ready
//   pix_data_o    pixel; channel c at [c*PIXEL_DEPTH +: PIXEL_DEPTH]
//   sof_o         current pixel is x=0, y=0
//   eol_o         current pixel is the last pixel of a line
//   eof_o         current pixel is the last pixel of the frame
//
// Optional feature (macro PIXEL_UNPACK_LINE_ALIGN_EN):
//   When the macro is defined, the residual bits are dropped at the end of
//   every line, so each line starts on a word boundary (padded stride).
//   When the macro is undefined, lines are packed contiguously and the
//   residual bits are dropped only at the end of the frame.

module pixel_unpack_stream #(
  parameter int WORD_W      = 32,
  parameter int PIXEL_DEPTH = 8,
  parameter int CHANNELS    = 3,
  parameter int IMG_WIDTH   = 1920,
  parameter int IMG_HEIGHT  = 1080
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            word_valid_i,
  input  logic [WORD_W-1:0]               word_data_i,
  output logic                            word_ready_o,
  output logic                            pix_valid_o,
  input  logic                            pix_ready_i,
  output logic [CHANNELS*PIXEL_DEPTH-1:0] pix_data_o,
  output logic                            sof_o,
  output logic                            eol_o,
  output logic                            eof_o
);

  localparam int PIX_W  = CHANNELS * PIXEL_DEPTH;
  localparam int BUF_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [FILL_W-1:0] PIX_F     = FILL_W'(PIX_W);
  localparam logic [FILL_W-1:0] WORD_F    = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] READY_LIM = FILL_W'(BUF_W - WORD_W);
  localparam logic [XW-1:0]     X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_HEIGHT - 1);

  logic [BUF_W-1:0]  buf_r, buf_next, shifted, inserted;
  logic [FILL_W-1:0] fill_r, fill_next, rem;
  logic [XW-1:0]     x_r, x_next;
  logic [YW-1:0]     y_r, y_next;
  logic              pop, push, at_eol, at_eof, discard;

  // A word is only accepted when it is guaranteed to fit even if no pixel
  // leaves this cycle, so ready never depends on pix_ready_i. During a
  // flush the incoming word is dropped anyway, so ready is held high.
  assign word_ready_o = flush_i || (fill_r <= READY_LIM);
  assign pix_valid_o  = (fill_r >= PIX_F);
  assign pix_data_o   = buf_r[PIX_W-1:0];

  assign at_eol = (x_r == X_LAST);
  assign at_eof = at_eol && (y_r == Y_LAST);
  assign sof_o  = pix_valid_o && (x_r == '0) && (y_r == '0);
  assign eol_o  = pix_valid_o && at_eol;
  assign eof_o  = pix_valid_o && at_eof;

  assign pop  = pix_valid_o && pix_ready_i;
  assign push = word_valid_i && word_ready_o;

`ifdef PIXEL_UNPACK_LINE_ALIGN_EN
  assign discard = pop && at_eol;
`else
  assign discard = pop && at_eof;
`endif

  // Buffer update: drop the popped pixel (or the whole residue at a
  // discard point), then append the new word directly above the bits that
  // remain. A push only happens with fill_r <= BUF_W-WORD_W, so the shifted
  // word always fits in the buffer.
  always_comb begin
    shifted  = pop ? (buf_r >> PIX_W) : buf_r;
    rem      = pop ? (fill_r - PIX_F) : fill_r;
    if (discard) begin
      shifted = '0;
      rem     = '0;
    end
    inserted  = push ? ({{WORD_W{1'b0}}, word_data_i} << rem) : '0;
    buf_next  = shifted | inserted;
    fill_next = rem + (push ? WORD_F : '0);
  end

  // Raster position advances once per consumed pixel.
  always_comb begin
    x_next = x_r;
    y_next = y_r;
    if (pop) begin
      if (at_eol) begin
        x_next = '0;
        y_next = at_eof ? '0 : y_r + 1'b1;
      end else begin
        x_next = x_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r  <= '0;
      fill_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else if (flush_i) begin
      buf_r  <= '0;
      fill_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else begin
      buf_r  <= buf_next;
      fill_r <= fill_next;
      x_r    <= x_next;
      y_r    <= y_next;
    end
  end

endmodule

// File: tb/tb_pixel_unpack_stream.sv
// tb_pixel_unpack_stream
//
// Directed bench for pixel_unpack_stream. Two instances share the stimulus:
//   dut_a  IMG_WIDTH=4, IMG_HEIGHT=2  (unpack, backpressure, markers,
//                                      flush, reset)
//   dut_b  IMG_WIDTH=3, IMG_HEIGHT=2  (frame residual / line alignment)
// Only the instance picked by 'sel' receives word_valid; its outputs are
// the ones observed. Expected values reflect PIXEL_UNPACK_LINE_ALIGN_EN.

module tb_pixel_unpack_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        word_valid;
  logic [31:0] word_data;
  logic        pix_ready;
  logic        sel;

  logic        wr_a, pv_a, sof_a, eol_a, eof_a;
  logic        wr_b, pv_b, sof_b, eol_b, eof_b;
  logic [23:0] pd_a, pd_b;

  logic        obs_wr, obs_valid;
  logic [23:0] obs_data;
  logic [2:0]  obs_flg;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [0:7];
  logic [23:0] exp_pix [0:7];
  logic [2:0]  exp_flg [0:7];

  logic [23:0] pix_q [$];
  logic [2:0]  flg_q [$];
  int          first_push;
  int          first_valid;
  bit          saw_wr0;

  always #5 clk = ~clk;

  pixel_unpack_stream #(
    .WORD_W(32), .PIXEL_DEPTH(8), .CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(2)
  ) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush),
    .word_valid_i(word_valid && !sel), .word_data_i(word_data),
    .word_ready_o(wr_a), .pix_valid_o(pv_a), .pix_ready_i(pix_ready),
    .pix_data_o(pd_a), .sof_o(sof_a), .eol_o(eol_a), .eof_o(eof_a)
  );

  pixel_unpack_stream #(
    .WORD_W(32), .PIXEL_DEPTH(8), .CHANNELS(3), .IMG_WIDTH(3), .IMG_HEIGHT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush),
    .word_valid_i(word_valid && sel), .word_data_i(word_data),
    .word_ready_o(wr_b), .pix_valid_o(pv_b), .pix_ready_i(pix_ready),
    .pix_data_o(pd_b), .sof_o(sof_b), .eol_o(eol_b), .eof_o(eof_b)
  );

  assign obs_wr    = sel ? wr_b : wr_a;
  assign obs_valid = sel ? pv_b : pv_a;
  assign obs_data  = sel ? pd_b : pd_a;
  assign obs_flg   = sel ? {sof_b, eol_b, eof_b} : {sof_a, eol_a, eof_a};

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("[TB] %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs and advance to just after the next edge.
  task automatic stepCycle(input logic v, input logic [31:0] d, input logic r);
    word_valid = v;
    word_data  = d;
    pix_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doFlush();
    word_valid = 1'b0;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Stream words[0..nwords-1] at full rate and record every consumed pixel.
  // toggle=1 alternates pix_ready 1/0 each cycle.
  task automatic applyStimulus(input int nwords, input bit toggle, input int budget);
    int          idx = 0;
    int          cyc = 0;
    bit          done = 1'b0;
    bit          holding = 1'b0;
    logic [23:0] held = '0;
    pix_q.delete();
    flg_q.delete();
    first_push  = -1;
    first_valid = -1;
    saw_wr0     = 1'b0;
    while (cyc < budget && !done) begin
      word_valid = (idx < nwords);
      word_data  = (idx < nwords) ? words[idx] : 32'h0;
      pix_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (holding) checkOutput("stall_hold", {8'h0, obs_data}, {8'h0, held});
      holding = obs_valid && !pix_ready;
      held    = obs_data;
      if (obs_valid && first_valid < 0) first_valid = cyc;
      if (!obs_wr) saw_wr0 = 1'b1;
      if (word_valid && obs_wr) begin
        if (first_push < 0) first_push = cyc;
        idx++;
      end
      if (obs_valid && pix_ready) begin
        pix_q.push_back(obs_data);
        flg_q.push_back(obs_flg);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (idx >= nwords && !obs_valid) done = 1'b1;
    end
    word_valid = 1'b0;
    checkOutput("stream_done", {31'h0, done}, 32'h1);
  endtask

  task automatic checkPixels(input string tag, input int n);
    checkOutput({tag, "_count"}, pix_q.size(), n);
    for (int i = 0; i < n && i < pix_q.size(); i++) begin
      checkOutput($sformatf("%s_pix%0d", tag, i), {8'h0, pix_q[i]}, {8'h0, exp_pix[i]});
      checkOutput($sformatf("%s_flg%0d", tag, i), {29'h0, flg_q[i]}, {29'h0, exp_flg[i]});
    end
  endtask

  task automatic setWords(input logic [31:0] w0, w1, w2, w3, w4, w5);
    words[0] = w0; words[1] = w1; words[2] = w2;
    words[3] = w3; words[4] = w4; words[5] = w5;
  endtask

  task automatic setExp(input int i, input logic [23:0] p, input logic [2:0] f);
    exp_pix[i] = p;
    exp_flg[i] = f;
  endtask

  // Three base words starting at raster origin on dut_a (4 pixels wide).
  task automatic setBasicExp();
    setWords(32'h33221100, 32'h77665544, 32'hBBAA9988, 32'h0, 32'h0, 32'h0);
    setExp(0, 24'h221100, 3'b100);
    setExp(1, 24'h554433, 3'b000);
    setExp(2, 24'h887766, 3'b000);
    setExp(3, 24'hBBAA99, 3'b010);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    pix_ready  = 1'b0;
    sel        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      words[i]   = '0;
      exp_pix[i] = '0;
      exp_flg[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_valid", {31'h0, obs_valid}, 32'h0);
    checkOutput("rst_data", {8'h0, obs_data}, 32'h0);
    checkOutput("rst_flags", {29'h0, obs_flg}, 32'h0);
    checkOutput("rst_ready", {31'h0, obs_wr}, 32'h1);
    @(posedge clk);
    #1;

    // Basic unpack with one-cycle latency
    setBasicExp();
    applyStimulus(3, 1'b0, 50);
    checkPixels("basic", 4);
    checkOutput("basic_latency", first_valid - first_push, 32'd1);
    doFlush();

    // Backpressure
    setBasicExp();
    applyStimulus(3, 1'b1, 80);
    checkPixels("bp", 4);
    checkOutput("bp_ready_drop", {31'h0, saw_wr0}, 32'h1);
    doFlush();

    // Raster markers over a full 4x2 frame, then the next frame
    setWords(32'h33221100, 32'h77665544, 32'hBBAA9988,
             32'hFFEEDDCC, 32'h13121110, 32'h17161514);
    setExp(0, 24'h221100, 3'b100);
    setExp(1, 24'h554433, 3'b000);
    setExp(2, 24'h887766, 3'b000);
    setExp(3, 24'hBBAA99, 3'b010);
    setExp(4, 24'hEEDDCC, 3'b000);
    setExp(5, 24'h1110FF, 3'b000);
    setExp(6, 24'h141312, 3'b000);
    setExp(7, 24'h171615, 3'b011);
    applyStimulus(6, 1'b0, 80);
    checkPixels("mark", 8);
    setBasicExp();
    applyStimulus(3, 1'b0, 50);
    checkPixels("mark_next", 4);

    // Flush mid-line (raster currently at x=0, y=1)
    stepCycle(1'b1, 32'h33221100, 1'b1);
    stepCycle(1'b1, 32'h77665544, 1'b1);
    stepCycle(1'b0, 32'h0, 1'b0);
    checkOutput("pre_flush_valid", {31'h0, obs_valid}, 32'h1);
    word_valid = 1'b1;
    word_data  = 32'hDEADBEEF;
    pix_ready  = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready", {31'h0, obs_wr}, 32'h1);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    word_valid = 1'b0;
    checkOutput("flush_valid", {31'h0, obs_valid}, 32'h0);
    checkOutput("flush_data", {8'h0, obs_data}, 32'h0);
    setBasicExp();
    applyStimulus(3, 1'b0, 50);
    checkPixels("flush_next", 4);

    // Asynchronous reset between clock edges mid-frame
    stepCycle(1'b1, 32'h33221100, 1'b1);
    stepCycle(1'b1, 32'h77665544, 1'b0);
    word_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_valid", {31'h0, obs_valid}, 32'h1);
    rst = 1'b1;
    #2;
    checkOutput("async_rst_valid", {31'h0, obs_valid}, 32'h0);
    checkOutput("async_rst_data", {8'h0, obs_data}, 32'h0);
    checkOutput("async_rst_ready", {31'h0, obs_wr}, 32'h1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    setBasicExp();
    applyStimulus(3, 1'b0, 50);
    checkPixels("rst_next", 4);

    // Residual discard on the 3x2 instance
    sel = 1'b1;
    doFlush();
    setWords(32'h33221100, 32'h77665544, 32'hBBAA9988,
             32'hFFEEDDCC, 32'h13121110, 32'h17161514);
    setExp(0, 24'h221100, 3'b100);
    setExp(1, 24'h554433, 3'b000);
    setExp(2, 24'h887766, 3'b010);
`ifdef PIXEL_UNPACK_LINE_ALIGN_EN
    setExp(3, 24'hEEDDCC, 3'b000);
    setExp(4, 24'h1110FF, 3'b000);
    setExp(5, 24'h141312, 3'b011);
    applyStimulus(6, 1'b0, 80);
`else
    setExp(3, 24'hBBAA99, 3'b000);
    setExp(4, 24'hEEDDCC, 3'b000);
    setExp(5, 24'h1110FF, 3'b011);
    applyStimulus(5, 1'b0, 80);
`endif
    checkPixels("resid", 6);
    words[0] = 32'h0C0B0A0D;
    setExp(0, 24'h0B0A0D, 3'b100);
    applyStimulus(1, 1'b0, 20);
    checkPixels("resid_next", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
